// File: rtl/vedic_mul32_seq.sv
// Sequential 32x32 unsigned multiplier that time-shares one 16x16 vedic core.
// Four partial products are accumulated into a 64-bit register, then held.

module vedic16x16ppa (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p,
    output logic        ccout
);
    logic [15:0] pll;
    logic [15:0] plh;
    logic [15:0] phl;
    logic [15:0] phh;
    logic [16:0] mid;
    logic [32:0] sum;

    // Urdhva split into 8x8 crosswise terms, merged by a parallel prefix add
    assign pll = {8'b0, a[7:0]} * {8'b0, b[7:0]};
    assign plh = {8'b0, a[7:0]} * {8'b0, b[15:8]};
    assign phl = {8'b0, a[15:8]} * {8'b0, b[7:0]};
    assign phh = {8'b0, a[15:8]} * {8'b0, b[15:8]};

    assign mid   = {1'b0, plh} + {1'b0, phl};
    assign sum   = {1'b0, phh, pll} + {8'b0, mid, 8'b0};
    assign p     = sum[31:0];
    assign ccout = sum[32];
endmodule

module vedic_mul32_seq #(
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] ai,
    input  logic [31:0] bi,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] sout,
    output logic        busy
);
    typedef enum logic [2:0] {
        IDLE,
        P0,
        P1,
        P2,
        P3,
        DONE
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [63:0] acc_q;
    logic [63:0] acc_d;
    logic [15:0] ma;
    logic [15:0] mb;
    logic [31:0] pp;
    logic        ccout_unused;
    logic        zero_op;

    always_comb begin
        ma = '0;
        mb = '0;
        unique case (state_q)
            P0: begin
                ma = a_q[15:0];
                mb = b_q[15:0];
            end
            P1: begin
                ma = a_q[31:16];
                mb = b_q[15:0];
            end
            P2: begin
                ma = a_q[15:0];
                mb = b_q[31:16];
            end
            P3: begin
                ma = a_q[31:16];
                mb = b_q[31:16];
            end
            default: ;
        endcase
    end

    // a 16x16 product never exceeds 32 bits, so the carry out is dropped
    vedic16x16ppa u_pp (
        .a    (ma),
        .b    (mb),
        .p    (pp),
        .ccout(ccout_unused)
    );

    assign zero_op = ZERO_BYPASS && ((ai == '0) || (bi == '0));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = '0;
                    state_d = zero_op ? DONE : P0;
                end
            end
            P0: begin
                acc_d   = acc_q + {32'b0, pp};
                state_d = P1;
            end
            P1: begin
                acc_d   = acc_q + {16'b0, pp, 16'b0};
                state_d = P2;
            end
            P2: begin
                acc_d   = acc_q + {16'b0, pp, 16'b0};
                state_d = P3;
            end
            P3: begin
                acc_d   = acc_q + {pp, 32'b0};
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            if (state_q == IDLE && in_valid) begin
                a_q <= ai;
                b_q <= bi;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sout      = acc_q;
endmodule

// File: tb/tb_vedic_mul32_seq.sv
// Bench for vedic_mul32_seq: directed vectors, backpressure, reset, random run.
// A latency-level model is compared against the DUT on every falling edge.

module tb_vedic_mul32_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] ai = '0;
    logic [31:0] bi = '0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] sout;
    logic        busy;
    logic        in_ready0;
    logic        out_valid0;
    logic [63:0] sout0;
    logic        busy0;

    int tests = 0;
    int fails = 0;

    vedic_mul32_seq dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ai       (ai),
        .bi       (bi),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sout     (sout),
        .busy     (busy)
    );

    vedic_mul32_seq #(.ZERO_BYPASS(1'b0)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready0),
        .ai       (ai),
        .bi       (bi),
        .out_valid(out_valid0),
        .out_ready(out_ready),
        .sout     (sout0),
        .busy     (busy0)
    );

    always #5 clk = ~clk;

    // model: an accepted pair yields its product 4 edges later, or at once if an operand is 0
    bit          m_idle = 1'b1;
    bit          m_done = 1'b0;
    int          m_cnt = 0;
    int          m_accepts = 0;
    logic [63:0] m_prod = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_idle = 1'b1;
            m_done = 1'b0;
            m_cnt  = 0;
            m_prod = '0;
        end else if (m_idle) begin
            if (in_valid) begin
                m_accepts++;
                m_idle = 1'b0;
                m_prod = 64'(ai) * 64'(bi);
                if (ai == 0 || bi == 0) m_done = 1'b1;
                else m_cnt = 4;
            end
        end else if (!m_done) begin
            m_cnt--;
            if (m_cnt == 0) m_done = 1'b1;
        end else if (out_ready) begin
            m_done = 1'b0;
            m_idle = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            tests++;
            if (in_ready !== m_idle || out_valid !== m_done || busy !== !m_idle) begin
                fails++;
                $display("FAIL flags t=%0t rdy/vld/busy got %b%b%b expected %b%b%b",
                         $time, in_ready, out_valid, busy, m_idle, m_done, !m_idle);
            end
            if (m_idle || m_done) begin
                tests++;
                if (sout !== m_prod) begin
                    fails++;
                    $display("FAIL sout t=%0t got %h expected %h", $time, sout, m_prod);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int exp_lat);
        int g;
        int lat;
        g = 0;
        while (!in_ready && g < 50) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk({name, "_ready"}, 64'(in_ready), 64'd1);
        ai       = a;
        bi       = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({name, "_model"}, m_prod, exp);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
        chk(name, sout, exp);
        if (out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int lat0;
        int base;
        int cyc;
        #3;
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sout", sout, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // zero operand: bypass instance finishes at once, the other takes 4 edges
        chk("zb0_ready", 64'(in_ready0), 64'd1);
        ai       = 32'h0;
        bi       = 32'hDEADBEEF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("zb1_valid", 64'(out_valid), 64'd1);
        chk("zb1_sout", sout, 64'd0);
        chk("zb0_busy", 64'(busy0), 64'd1);
        lat0 = 0;
        while (!out_valid0 && lat0 < 20) begin
            @(posedge clk);
            #1;
            lat0++;
        end
        chk("zb0_lat", 64'(lat0), 64'd4);
        chk("zb0_sout", sout0, 64'd0);
        @(posedge clk);
        #1;

        run_op("full", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 4);
        run_op("cross1", 32'h00010000, 32'h00010000, 64'h0000000100000000, 4);
        run_op("cross2", 32'h80000000, 32'h00000002, 64'h0000000100000000, 4);
        run_op("small", 32'd3, 32'd5, 64'd15, 4);
        run_op("lowhalf", 32'h0000FFFF, 32'h0000FFFF, 64'h00000000FFFE0001, 4);
        run_op("midcarry", 32'h00010001, 32'h00010001, 64'h0000000100020001, 4);
        run_op("shift1", 32'h12345678, 32'h00000002, 64'h000000002468ACF0, 4);
        run_op("ident", 32'hFFFFFFFF, 32'h00000001, 64'h00000000FFFFFFFF, 4);
        run_op("bzero", 32'h00001234, 32'h0, 64'd0, 0);

        // backpressure with an ignored operand pair presented while DONE
        out_ready = 1'b0;
        run_op("bp", 32'd7, 32'd6, 64'd42, 4);
        ai       = 32'd9;
        bi       = 32'd9;
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_ready", 64'(in_ready), 64'd0);
            chk("bp_sout", sout, 64'd42);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_rel_valid", 64'(out_valid), 64'd0);
        chk("bp_rel_ready", 64'(in_ready), 64'd1);
        chk("bp_rel_sout", sout, 64'd42);

        // reset while the third partial product is pending
        ai       = 32'h12345678;
        bi       = 32'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        chk("mrst_ready", 64'(in_ready), 64'd1);
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_sout", sout, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        chk("mrst_quiet", 64'(out_valid), 64'd0);
        run_op("after_rst", 32'd3, 32'd5, 64'd15, 4);

        // random regression with stalls; the compare process checks every product
        base = m_accepts;
        cyc  = 0;
        while ((m_accepts - base) < 10000 && cyc < 90000) begin
            @(posedge clk);
            #1;
            cyc++;
            ai        = ($urandom_range(15) == 0) ? 32'h0 : $urandom;
            bi        = ($urandom_range(15) == 0) ? 32'h0 :
                        ($urandom_range(15) == 0) ? 32'hFFFFFFFF : $urandom;
            in_valid  = 1'b1;
            out_ready = ($urandom_range(3) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("regress_ops", 64'((m_accepts - base) >= 10000), 64'd1);
        repeat (8) @(posedge clk);
        #1;
        chk("final_idle", 64'(in_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "timeout");
    end
endmodule
